// File: rtl/poly_pack_pkg.sv
// Shared constants, FSM encoding and word-count helpers for the
// polynomial packer (13-bit packing, optional 16-bit passthrough).
package poly_pack_pkg;

    localparam int N_COEFF_DEF = 256;

    // Bits appended to the pack buffer per accepted input
    localparam int ACC_W13 = 52;
    localparam int ACC_W16 = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int words13(input int n);
        return n * 13 / 64;
    endfunction

    function automatic int words16(input int n);
        return n / 4;
    endfunction

    // Word counts for the default polynomial size (52 and 64)
    localparam int WORDS13 = words13(N_COEFF_DEF);
    localparam int WORDS16 = words16(N_COEFF_DEF);

endpackage

// File: rtl/pack_shifter.sv
// 128-bit LSB-first pack buffer with fill count; appends 52 or 64 bits per
// accept and drops the low 64-bit word on emit, both in the same cycle.
// Ports: clk, rst (async active-low), clear (sync flush), accept, emit,
//        mode16, data[63:0] in; fill, fill_after, word[63:0] out.
module pack_shifter
    import poly_pack_pkg::*;
#(
    parameter int COEFF_W = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic        emit,
    input  logic        mode16,
    input  logic [63:0] data,
    output logic [7:0]  fill,
    output logic [7:0]  fill_after,
    output logic [63:0] word
);

    logic [127:0] data_buf;
    logic [127:0] shifted;
    logic [127:0] ext;
    logic [63:0]  packed_data;
    logic [7:0]   base;
    logic [7:0]   acc_w;

    always_comb begin
        packed_data = '0;
        for (int j = 0; j < 4; j++) begin
            packed_data[j*COEFF_W +: COEFF_W] = data[16*j +: COEFF_W];
        end
        ext     = {64'd0, (mode16 ? data : packed_data)};
        shifted = emit ? {64'd0, data_buf[127:64]} : data_buf;
        base    = emit ? (fill - 8'd64) : fill;
        acc_w   = mode16 ? 8'(ACC_W16) : 8'(ACC_W13);
    end

    // Bits above the fill level are always zero, so OR-in is enough
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_buf <= '0;
            fill     <= '0;
        end else if (clear) begin
            data_buf <= '0;
            fill     <= '0;
        end else begin
            data_buf <= accept ? (shifted | (ext << base)) : shifted;
            fill     <= accept ? (base + acc_w) : base;
        end
    end

    assign fill_after = base;
    assign word       = data_buf[63:0];

endmodule

// File: rtl/poly_pack13_writer.sv
// Packs one polynomial of N_COEFF coefficients into 64-bit BRAM words,
// 13 bits per coefficient (or 16-bit passthrough when POLY_PACK_MODE16_EN
// is defined and mode16 is set at start).
// Ports: clk, rst (async active-low), start, mode16, in_valid, in_data in;
//        in_ready, bram_we, bram_addr[6:0], bram_wdata[63:0], busy, done out.
module poly_pack13_writer
    import poly_pack_pkg::*;
#(
    parameter int N_COEFF = N_COEFF_DEF,
    parameter int COEFF_W = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode16,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        bram_we,
    output logic [6:0]  bram_addr,
    output logic [63:0] bram_wdata,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] ACC_MAX  = 16'(N_COEFF / 4);
    localparam logic [15:0] WORDS_13 = 16'(words13(N_COEFF));
    localparam logic [15:0] WORDS_16 = 16'(words16(N_COEFF));

    state_t      state;
    logic [15:0] acc_cnt;
    logic [15:0] wcnt;
    logic [15:0] total;
    logic [7:0]  fill;
    logic [7:0]  fill_after;
    logic [7:0]  room;
    logic [63:0] word;
    logic        mode_q;
    logic        accept;
    logic        emit;
    logic        go;

    assign go = (state == S_IDLE) && start;

`ifdef POLY_PACK_MODE16_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= 1'b0;
        end else if (go) begin
            mode_q <= mode16;
        end
    end
`else
    logic unused_mode16;
    assign unused_mode16 = mode16;
    assign mode_q        = 1'b0;
`endif

    assign total = mode_q ? WORDS_16 : WORDS_13;
    assign room  = mode_q ? 8'(128 - ACC_W16) : 8'(128 - ACC_W13);

    // Room is judged after this cycle's emit so 13-bit mode keeps 1 input/cycle
    assign in_ready = (state == S_RUN) && (acc_cnt < ACC_MAX)
                   && (fill_after <= room);
    assign accept = in_valid && in_ready;
    assign emit   = (state == S_RUN) && (fill >= 8'd64) && (wcnt < total);

    pack_shifter #(
        .COEFF_W (COEFF_W)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .clear      (go),
        .accept     (accept),
        .emit       (emit),
        .mode16     (mode_q),
        .data       (in_data),
        .fill       (fill),
        .fill_after (fill_after),
        .word       (word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            acc_cnt    <= '0;
            wcnt       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_wdata <= '0;
        end else begin
            bram_we <= 1'b0;
            done    <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_RUN;
                        busy    <= 1'b1;
                        acc_cnt <= '0;
                        wcnt    <= '0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + 16'd1;
                    end
                    if (emit) begin
                        bram_we    <= 1'b1;
                        bram_addr  <= wcnt[6:0];
                        bram_wdata <= word;
                        wcnt       <= wcnt + 16'd1;
                    end
                    // Last word is on the port this cycle
                    if (bram_we && (wcnt == total)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_pack13_writer.sv
// Directed bench for poly_pack13_writer: packing vectors, gaps, ignored
// starts, mid-run reset, all-ones data, 16-bit mode when enabled.
module tb_poly_pack13_writer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mode16;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        bram_we;
    logic [6:0]  bram_addr;
    logic [63:0] bram_wdata;
    logic        busy;
    logic        done;

    poly_pack13_writer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode16     (mode16),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    int          cyc = 0;
    int          n_done = 0;
    int          done_cyc = 0;
    int          start_cyc = 0;
    logic [6:0]  wr_addr[$];
    logic [63:0] wr_data[$];

    logic [63:0]   stim[64];
    logic [63:0]   exp_w[64];
    logic [3327:0] stream;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bram_we) begin
            wr_addr.push_back(bram_addr);
            wr_data.push_back(bram_wdata);
        end
        if (done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: coefficient i at stream bits [13i+12:13i]
    task automatic build13();
        logic [15:0] c;
        stream = '0;
        for (int i = 0; i < 256; i++) begin
            c = stim[i/4][16*(i%4) +: 16];
            stream[13*i +: 13] = c[12:0];
        end
        for (int k = 0; k < 52; k++) exp_w[k] = stream[64*k +: 64];
    endtask

    task automatic run_poly(input logic m16, input bit gaps, input bit extra,
                            input int abort_at, output int ncyc);
        int  idx;
        int  n;
        bit  acc;
        idx = 0;
        n   = 0;
        @(negedge clk);
        start     = 1'b1;
        mode16    = m16;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        while (idx < 64 && idx != abort_at && n < 400) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = stim[idx];
            start    = extra && (n % 5 == 2);
            acc      = in_valid && in_ready;
            @(negedge clk);
            if (acc) idx++;
            n++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("feed_in_time", 64'(n < 400), 64'd1);
        ncyc = n;
    endtask

    task automatic check_poly(input string tag, input int base, input int d0,
                              input int nw, input bit lat);
        int k;
        k = 0;
        while (n_done == d0 && k < 150) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_done_once"}, 64'(n_done - d0), 64'd1);
        if (lat) chk({tag, "_latency_le80"},
                     64'((done_cyc - start_cyc) <= 80), 64'd1);
        chk({tag, "_writes"}, 64'(wr_addr.size() - base), 64'(nw));
        for (int i = 0; i < nw; i++) begin
            if (base + i < wr_addr.size()) begin
                chk($sformatf("%s_addr%0d", tag, i),
                    64'(wr_addr[base+i]), 64'(i));
                chk($sformatf("%s_word%0d", tag, i),
                    wr_data[base+i], exp_w[i]);
            end
        end
    endtask

    initial begin
        int ncyc;
        int b;
        int d;
        rst      = 1'b0;
        start    = 1'b0;
        mode16   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_bram_we", 64'(bram_we), 64'd0);
        chk("rst_bram_addr", 64'(bram_addr), 64'd0);
        chk("rst_bram_wdata", bram_wdata, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Known first words plus random remainder, back-to-back
        for (int i = 0; i < 64; i++) stim[i] = {$urandom, $urandom};
        stim[0] = {16'd4, 16'd3, 16'd2, 16'd1};
        stim[1] = {16'd8, 16'd7, 16'd6, 16'd5};
        build13();
        b = wr_addr.size();
        d = n_done;
        run_poly(1'b0, 1'b0, 1'b0, -1, ncyc);
        chk("b2b_busy", 64'(busy), 64'd1);
        check_poly("b2b", b, d, 52, 1'b1);
        if (wr_data.size() > b) begin
            chk("vec_word0", wr_data[b], 64'h0050_0200_0C00_4001);
        end

        // Same data with random gaps and stray start pulses
        b = wr_addr.size();
        d = n_done;
        run_poly(1'b0, 1'b1, 1'b1, -1, ncyc);
        chk("gap_ready_after_64", 64'(in_ready), 64'd0);
        check_poly("gap", b, d, 52, 1'b0);

        // Reset after 20 accepts
        run_poly(1'b0, 1'b0, 1'b0, 20, ncyc);
        rst = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_bram_we", 64'(bram_we), 64'd0);
        chk("mid_rst_bram_addr", 64'(bram_addr), 64'd0);
        chk("mid_rst_bram_wdata", bram_wdata, 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        b = wr_addr.size();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_no_write", 64'(wr_addr.size() - b), 64'd0);
        chk("post_rst_idle", 64'(in_ready), 64'd0);
        for (int i = 0; i < 64; i++) stim[i] = {$urandom, $urandom};
        build13();
        b = wr_addr.size();
        d = n_done;
        run_poly(1'b0, 1'b0, 1'b0, -1, ncyc);
        check_poly("rerun", b, d, 52, 1'b1);

        // All-ones coefficients: upper 3 bits dropped, words all ones
        for (int i = 0; i < 64; i++) stim[i] = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int k = 0; k < 52; k++) exp_w[k] = 64'hFFFF_FFFF_FFFF_FFFF;
        b = wr_addr.size();
        d = n_done;
        run_poly(1'b0, 1'b0, 1'b0, -1, ncyc);
        check_poly("ones", b, d, 52, 1'b1);

`ifdef POLY_PACK_MODE16_EN
        for (int i = 0; i < 64; i++) begin
            stim[i]  = 64'(i);
            exp_w[i] = 64'(i);
        end
        b = wr_addr.size();
        d = n_done;
        run_poly(1'b1, 1'b0, 1'b0, -1, ncyc);
        chk("m16_one_per_cycle", 64'(ncyc), 64'd64);
        check_poly("m16", b, d, 64, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
